// File: rtl/fp_normalize.sv
// fp_normalize: normalizes a raw floating-point sum into a packed IEEE-754
// single. A carry is handled with one right shift. A missing hidden bit is
// handled with left shifts, one per cycle, until the hidden bit is set or the
// exponent reaches its denormal floor. The output is held in DONE until it is
// taken.
module fp_normalize (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sum_sign,
  input  logic [7:0]  sum_exp,
  input  logic [24:0] sum_mantissa,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic        sign_q;
  logic [24:0] mant_q;
  logic [7:0]  exp_q;
  logic [31:0] result_q;
  logic        overflow_q;
  logic        underflow_q;
  logic        zero_q;
  logic [7:0]  exp_inc;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign zero      = zero_q;

  // Exponent after a carry right-shift. The working exponent never exceeds
  // 0xFE here because 0xFF inputs bypass NORM, so this cannot wrap.
  assign exp_inc = exp_q + 8'd1;

  // Control FSM plus the working and result registers. All three flags are
  // written on every entry to DONE, so at most one of them is ever set.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it lives inside the
    // clocked block. Every register, including the working mantissa and
    // exponent, is cleared so that nothing from an aborted operation leaks
    // out.
    if (!rst_n) begin
      state       <= IDLE;
      sign_q      <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= sum_sign;
            mant_q <= sum_mantissa;
            exp_q  <= (sum_exp == 8'h00) ? 8'h01 : sum_exp;
            if (sum_exp == 8'hFF) begin
              // Inf/NaN: pass the fraction through untouched.
              result_q    <= {sum_sign, 8'hFF, sum_mantissa[22:0]};
              overflow_q  <= 1'b0;
              underflow_q <= 1'b0;
              zero_q      <= 1'b0;
              state       <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (mant_q == 25'd0) begin
            result_q    <= {sign_q, 31'd0};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b1;
            state       <= DONE;
          end else if (mant_q[24]) begin
            // Carry: shift right by one and truncate the LSB.
            mant_q <= mant_q >> 1;
            exp_q  <= exp_inc;
            if (exp_inc == 8'hFF) begin
              result_q   <= {sign_q, 8'hFF, 23'd0};
              overflow_q <= 1'b1;
            end else begin
              result_q   <= {sign_q, exp_inc, mant_q[23:1]};
              overflow_q <= 1'b0;
            end
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
            state       <= DONE;
          end else if (mant_q[23]) begin
            result_q    <= {sign_q, exp_q, mant_q[22:0]};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            zero_q      <= 1'b0;
            state       <= DONE;
          end else if (exp_q == 8'h01) begin
            // Exponent floor reached without a hidden bit: denormal.
            result_q    <= {sign_q, 8'h00, mant_q[22:0]};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b1;
            zero_q      <= 1'b0;
            state       <= DONE;
          end else begin
            // One left shift per cycle. A nonzero mantissa with bit 23 clear
            // reaches bit 23 within 23 shifts, which bounds the loop.
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - 8'd1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize.sv
// Directed testbench for fp_normalize. Expected results are hand-computed.
// Inputs change on the falling edge, and outputs are sampled there too.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sum_sign;
  logic [7:0]  sum_exp;
  logic [24:0] sum_mantissa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  fp_normalize dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sum_sign     (sum_sign),
    .sum_exp      (sum_exp),
    .sum_mantissa (sum_mantissa),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .overflow     (overflow),
    .underflow    (underflow),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one sum, then measure the latency, check the result and flags
  // ({overflow, underflow, zero}), and complete the output handshake.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [24:0] m, input logic [31:0] exp_res,
                        input logic [2:0] exp_flags, input int exp_lat);
    int cyc;
    @(negedge clk);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid     = 1'b1;
    sum_sign     = s;
    sum_exp      = e;
    sum_mantissa = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, cyc, exp_lat);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".flags"}, {29'd0, overflow, underflow, zero}, {29'd0, exp_flags});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".done_clear"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    rst_n        = 1'b0;
    in_valid     = 1'b1;  // asserted during reset; it must be ignored
    sum_sign     = 1'b0;
    sum_exp      = 8'h80;
    sum_mantissa = 25'h0800000;
    out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("reset.result", result, 32'h0);
    check("reset.flags", {29'd0, overflow, underflow, zero}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    run_op("aligned",   1'b0, 8'h80, 25'h0800000, 32'h40000000, 3'b000, 2);
    run_op("carry",     1'b0, 8'h7F, 25'h1000000, 32'h40000000, 3'b000, 2);
    run_op("carry_ovf", 1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b100, 2);
    run_op("carry_trunc", 1'b0, 8'h10, 25'h1FFFFFF, 32'h08FFFFFF, 3'b000, 2);
    run_op("left3",     1'b0, 8'h85, 25'h0100000, 32'h41000000, 3'b000, 5);
    run_op("zero_neg",  1'b1, 8'h40, 25'h0000000, 32'h80000000, 3'b001, 2);
    run_op("denormal",  1'b0, 8'h02, 25'h0000001, 32'h00000002, 3'b010, 3);
    run_op("exp_zero",  1'b0, 8'h00, 25'h0800000, 32'h00800000, 3'b000, 2);
    run_op("inf_nan",   1'b1, 8'hFF, 25'h0400001, 32'hFFC00001, 3'b000, 1);
    run_op("left23",    1'b0, 8'h80, 25'h0000001, 32'h34800000, 3'b000, 25);

    // Backpressure: hold the result in DONE while a second sum waits upstream.
    @(negedge clk);
    in_valid     = 1'b1;
    sum_sign     = 1'b0;
    sum_exp      = 8'h80;
    sum_mantissa = 25'h0800000;
    @(negedge clk);
    sum_exp = 8'h81;  // the next sum, held from now on
    @(negedge clk);
    check("bp.out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp.hold_result", result, 32'h40000000);
      check("bp.hold_ready_valid", {30'd0, in_ready, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.idle_after_handshake", {30'd0, in_ready, out_valid}, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.second_accepted", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("bp.second_valid", {31'd0, out_valid}, 32'd1);
    check("bp.second_result", result, 32'h40800000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a long left-normalization.
    @(negedge clk);
    in_valid     = 1'b1;
    sum_sign     = 1'b1;
    sum_exp      = 8'h90;
    sum_mantissa = 25'h0000010;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid.in_norm", {30'd0, in_ready, out_valid}, 32'd0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("rst_mid.ready_valid", {30'd0, in_ready, out_valid}, 32'd2);
    check("rst_mid.result", result, 32'h0);
    check("rst_mid.flags", {29'd0, overflow, underflow, zero}, 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_mid.no_out_valid", seen, 32'd0);

    run_op("after_reset", 1'b0, 8'h80, 25'h0800000, 32'h40000000, 3'b000, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
